lut_index_finder: RTL and testbench
===================================

LUT_INDEX_FINDER -- requirements
Module: lut_index_finder

Interface
REQ-001 The interface SHALL provide parameter LUT_DEPTH, default 21, meaning the number of populated table entries searched (indices 0..LUT_DEPTH-1).
REQ-002 The interface SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The interface SHALL provide port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The interface SHALL provide port req_valid, input, 1 bit: a lookup request is present.
REQ-005 The interface SHALL provide port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The interface SHALL provide port req_value, input, 8 bits: the data value to reverse-look-up.
REQ-007 The interface SHALL provide port rsp_valid, output, 1 bit: a response is present.
REQ-008 The interface SHALL provide port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-009 The interface SHALL provide port rsp_found, output, 1 bit: 1 = match found, 0 = miss.
REQ-010 The interface SHALL provide port rsp_index, output, 5 bits: the matching table address; 0 on a miss.
REQ-011 The interface SHALL provide port miss_count, output, 8 bits: the saturating count of completed misses.

Function
REQ-012 The block SHALL implement the inverse of the forward table mem_LUT (address -> data): value -> lowest address whose entry equals the value.
REQ-013 The FSM SHALL have states IDLE, SEARCH and DONE; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in DONE.
REQ-014 A request SHALL be accepted on an edge with req_valid=1 in IDLE; that edge SHALL latch req_value, set the scan address to 0 and enter SEARCH.
REQ-015 In SEARCH the block SHALL compare one entry per cycle: entry(addr) is read combinationally and compared with the latched value.
REQ-016 On equality the next edge SHALL enter DONE with rsp_found=1 and rsp_index=addr.
REQ-017 If entry(addr) > value (monotonic table, early exit) or addr = LUT_DEPTH-1 without equality, the next edge SHALL enter DONE with rsp_found=0, rsp_index=0, and increment miss_count unless it is already 255.
REQ-018 Otherwise the scan address SHALL increment by 1; it SHALL never exceed LUT_DEPTH-1, and entries at addresses >= LUT_DEPTH SHALL never be read.
REQ-019 Latency SHALL be k+1 cycles from the accept edge to rsp_valid=1 for a hit at index k; for a miss, it SHALL be m+1 cycles, where m is the address at which the miss is decided.
REQ-020 rsp_valid, rsp_found and rsp_index SHALL be held stable in DONE until an edge with rsp_ready=1, which SHALL return the FSM to IDLE.
REQ-021 There SHALL be no same-cycle response/request overlap: a new request SHALL be accepted no earlier than the edge after the response transfer.
REQ-022 req_value changes while not in IDLE SHALL have no effect.
REQ-023 rsp_found and rsp_index SHALL read 0 whenever rsp_valid=0.

Reset
REQ-024 Reset SHALL take priority over all other inputs at any edge, including mid-SEARCH and in DONE with a pending response.
REQ-025 After reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_found=0, rsp_index=0, miss_count=0, scan address=0, latched value=0.
REQ-026 A request in flight at reset SHALL be discarded with no response.

Structure
REQ-027 Shared package lut_pkg SHALL hold ADDR_W=5, DATA_W=8, the default LUT_DEPTH=21, and the FSM state enum type.
REQ-028 The block SHALL instantiate exactly one sub-module, mem_LUT, driven by the scan address, as its table source; it SHALL NOT keep a private copy of the table.
REQ-029 The RTL SHALL consist of one registered FSM process and a combinational next-state/output process.

Verification
REQ-030 The bench SHALL cover: reset, then req_value=60 -> rsp_valid after 1 cycle, found=1, index=0.
REQ-031 The bench SHALL cover: req_value=80 -> rsp_valid after 21 cycles, found=1, index=20; req_value=73 -> 14 cycles, index=13.
REQ-032 The bench SHALL cover: req_value=59 -> miss after 1 cycle (early exit, index=0), and req_value=81 -> miss after 21 cycles; miss_count=2.
REQ-033 The bench SHALL cover: hold rsp_ready=0 for 10 cycles after a hit on 65 -> rsp_valid, found=1 and index=5 stable throughout, and req_ready=0 throughout.
REQ-034 The bench SHALL cover: assert reset during SEARCH for value 78 at addr=9 -> next cycle IDLE, rsp_valid never asserted, miss_count unchanged.
REQ-035 The bench SHALL cover: 300 consecutive misses with value 200 -> miss_count saturates at 255.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared definitions for the LUT reverse-lookup block.
//   ADDR_W            - table address width
//   DATA_W            - table entry width
//   DEFAULT_LUT_DEPTH - number of populated entries searched by default
//   state_e           - lookup FSM state encoding
package lut_pkg;

   localparam int unsigned ADDR_W            = 5;
   localparam int unsigned DATA_W            = 8;
   localparam int unsigned DEFAULT_LUT_DEPTH = 21;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSearch = 2'd1,
      StDone   = 2'd2
   } state_e;

endpackage

// File: rtl/lut_index_finder_if.sv
// Request/response bundle for lut_index_finder.
//   req_valid/req_ready/req_value        - lookup request handshake
//   rsp_valid/rsp_ready/rsp_found/index  - lookup response handshake
//   miss_count                           - saturating count of completed misses
// master: requester side; slave: the lookup block.
interface lut_index_finder_if;
   import lut_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_value;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_found;
   logic [ADDR_W-1:0] rsp_index;
   logic [7:0]        miss_count;

   modport master (
      output req_valid, req_value, rsp_ready,
      input  req_ready, rsp_valid, rsp_found, rsp_index, miss_count
   );

   modport slave (
      input  req_valid, req_value, rsp_ready,
      output req_ready, rsp_valid, rsp_found, rsp_index, miss_count
   );

endinterface

// File: rtl/mem_LUT.sv
// Forward lookup table (address -> data), purely combinational.
// Populated entries form a strictly increasing ramp 60, 61, ... 80 at
// addresses 0..DEFAULT_LUT_DEPTH-1; unpopulated addresses return all ones.
//   addr_i - table address
//   data_o - table entry at addr_i
module mem_LUT
   import lut_pkg::*;
(
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] data_o
);

   localparam logic [DATA_W-1:0] BaseValue = DATA_W'(60);

   always_comb begin
      data_o = '1;
      if (32'(addr_i) < DEFAULT_LUT_DEPTH) begin
         data_o = BaseValue + DATA_W'(addr_i);
      end
   end

endmodule

// File: rtl/lut_index_finder.sv
// Reverse lookup over mem_LUT: returns the lowest address whose entry equals
// the requested value, scanning one entry per cycle from address 0.
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - request/response handshake plus miss counter (slave side)
module lut_index_finder
   import lut_pkg::*;
#(
   parameter int unsigned LUT_DEPTH = DEFAULT_LUT_DEPTH
) (
   input logic                clk,
   input logic                reset,
   lut_index_finder_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LUT_DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic              found_q, found_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [7:0]        miss_q, miss_d;
   logic [DATA_W-1:0] entry;

   mem_LUT u_mem_lut (
      .addr_i (addr_q),
      .data_o (entry)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      value_d = value_q;
      found_d = found_q;
      index_d = index_q;
      miss_d  = miss_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               value_d = bus.req_value;
               addr_d  = '0;
               state_d = StSearch;
            end
         end
         StSearch: begin
            if (entry == value_q) begin
               found_d = 1'b1;
               index_d = addr_q;
               state_d = StDone;
            end else if (entry > value_q || addr_q == LastAddr) begin
               // Table is monotonic, so a larger entry means no later match.
               found_d = 1'b0;
               index_d = '0;
               state_d = StDone;
               if (miss_q != 8'hFF) begin
                  miss_d = miss_q + 8'd1;
               end
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         StDone: begin
            if (bus.rsp_ready) begin
               // Clear result so it reads zero outside DONE.
               found_d = 1'b0;
               index_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         value_q <= '0;
         found_q <= 1'b0;
         index_q <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         value_q <= value_d;
         found_q <= found_d;
         index_q <= index_d;
         miss_q  <= miss_d;
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.rsp_valid  = (state_q == StDone);
   assign bus.rsp_found  = found_q;
   assign bus.rsp_index  = index_q;
   assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_lut_index_finder.sv
// Self-checking bench for lut_index_finder: directed vector table, hand-written
// hold/reset sequences, randomized lookups against an arithmetic model of the
// ramp table (entry(i) = 60 + i, i = 0..20), and miss counter saturation.
module tb_lut_index_finder;

   localparam int TblBase  = 60;
   localparam int TblDepth = 21;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   exp_miss;

   lut_index_finder_if bus ();

   lut_index_finder #(
      .LUT_DEPTH (TblDepth)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] value;
      bit         found;
      int         index;
      int         lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: hit iff value lies on the ramp; a value below the ramp is
   // rejected at address 0, above it only after the last entry.
   task automatic ref_lookup(input logic [7:0] v, output bit f, output int idx, output int lat);
      int iv;
      iv = int'(v);
      if (iv >= TblBase && iv < TblBase + TblDepth) begin
         f = 1'b1; idx = iv - TblBase; lat = idx + 1;
      end else if (iv < TblBase) begin
         f = 1'b0; idx = 0; lat = 1;
      end else begin
         f = 1'b0; idx = 0; lat = TblDepth;
      end
   endtask

   // Issue one request; returns result and cycles from accept edge to rsp_valid.
   task automatic transact(input logic [7:0] v, output bit f, output int idx, output int lat);
      @(negedge clk);
      check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_value = v;
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (lat < 64) begin
         bus.req_value = 8'($urandom);  // must be ignored outside IDLE
         @(posedge clk);
         #1;
         lat++;
         if (bus.rsp_valid) break;
      end
      f   = bus.rsp_found;
      idx = int'(bus.rsp_index);
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      check("rsp_valid_after_release", 32'(bus.rsp_valid), 32'd0);
      check("rsp_found_after_release", 32'(bus.rsp_found), 32'd0);
   endtask

   task automatic run_and_compare(input string tag, input logic [7:0] v);
      bit f, ef;
      int idx, eidx, lat, elat;
      ref_lookup(v, ef, eidx, elat);
      transact(v, f, idx, lat);
      if (!ef && exp_miss < 255) exp_miss++;
      check({tag, "_found"}, 32'(f), 32'(ef));
      check({tag, "_index"}, 32'(idx), 32'(eidx));
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      check({tag, "_miss_count"}, 32'(bus.miss_count), 32'(exp_miss));
      release_rsp();
   endtask

   initial begin
      vec_t vecs[5];
      bit   f;
      int   idx, lat, seen;
      logic [7:0] v;

      checks = 0; failures = 0; exp_miss = 0;
      bus.req_valid = 1'b0;
      bus.req_value = 8'd0;
      bus.rsp_ready = 1'b0;

      vecs[0] = '{value: 8'd60, found: 1'b1, index: 0,  lat: 1};
      vecs[1] = '{value: 8'd80, found: 1'b1, index: 20, lat: 21};
      vecs[2] = '{value: 8'd73, found: 1'b1, index: 13, lat: 14};
      vecs[3] = '{value: 8'd59, found: 1'b0, index: 0,  lat: 1};
      vecs[4] = '{value: 8'd81, found: 1'b0, index: 0,  lat: 21};

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", 32'(bus.req_ready), 32'd1);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_found", 32'(bus.rsp_found), 32'd0);
      check("reset_rsp_index", 32'(bus.rsp_index), 32'd0);
      check("reset_miss_count", 32'(bus.miss_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset during SEARCH for 78 while scanning address 9
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_value = 8'd78;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_req_ready", 32'(bus.req_ready), 32'd1);
      check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midreset_miss_count", 32'(bus.miss_count), 32'(exp_miss));
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) seen++;
      end
      check("midreset_no_response", 32'(seen), 32'd0);

      // Directed vector table
      for (int i = 0; i < 5; i++) begin
         transact(vecs[i].value, f, idx, lat);
         if (!vecs[i].found) exp_miss++;
         check("vec_found", 32'(f), 32'(vecs[i].found));
         check("vec_index", 32'(idx), 32'(vecs[i].index));
         check("vec_latency", 32'(lat), 32'(vecs[i].lat));
         release_rsp();
      end
      check("vec_miss_count", 32'(bus.miss_count), 32'd2);

      // Response held under back-pressure after hit on 65
      transact(8'd65, f, idx, lat);
      check("hold_found", 32'(f), 32'd1);
      check("hold_index", 32'(idx), 32'd5);
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!bus.rsp_valid || !bus.rsp_found || bus.rsp_index != 5'd5 || bus.req_ready) seen++;
      end
      check("hold_stable_cycles_bad", 32'(seen), 32'd0);
      release_rsp();

      // Randomized lookups against the model
      for (int i = 0; i < 40; i++) begin
         v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(55, 85));
         run_and_compare("rand", v);
      end

      // Miss counter saturation
      for (int i = 0; i < 300; i++) begin
         run_and_compare("sat", 8'd200);
      end
      check("sat_final_miss_count", 32'(bus.miss_count), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
